// File: rtl/dram_gen2_pkg.sv
// Shared state encoding, default timing constants and elaboration-time helpers for the
// 68000 DRAM controller.
package dram_gen2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRow,
        StCol,
        StPre,
        StRcas,
        StRras,
        StRpre
    } dram_state_e;

    localparam int unsigned DefTRcd      = 1;
    localparam int unsigned DefTRp       = 2;
    localparam int unsigned DefTRfc      = 2;
    localparam int unsigned DefRefPeriod = 120;
    localparam int unsigned DefRefMax    = 3;

    // Bit width needed to index n items, never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer feeding a saturating count of owed refresh cycles.
module dram_refresh_timer
    import dram_gen2_pkg::*;
#(
    parameter int unsigned REF_PERIOD = DefRefPeriod,
    parameter int unsigned REF_MAX    = DefRefMax
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       dec_i,
    output logic       pending_o,
    output logic       urgent_o,
    output logic       urgent_next_o,
    output logic [1:0] ref_pend_o
);

    localparam int unsigned       TimerW    = width_of(REF_PERIOD);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(REF_PERIOD - 1);
    localparam logic [1:0]        PendMax   = 2'(REF_MAX);

    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        pend_q, pend_d;
    logic              wrap;

    always_comb begin
        wrap    = (timer_q == TimerLast);
        timer_d = wrap ? '0 : timer_q + 1'b1;
        pend_d  = pend_q;
        // A wrap coinciding with a completed refresh cancels out.
        if (wrap && !dec_i) begin
            if (pend_q != PendMax) pend_d = pend_q + 2'd1;
        end else if (dec_i && !wrap) begin
            if (pend_q != 2'd0) pend_d = pend_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
            pend_q  <= 2'd0;
        end else begin
            timer_q <= timer_d;
            pend_q  <= pend_d;
        end
    end

    assign pending_o     = (pend_q != 2'd0);
    assign urgent_o      = (pend_q == PendMax);
    assign urgent_next_o = (pend_d == PendMax);
    assign ref_pend_o    = pend_q;

endmodule

// File: rtl/dram_ctl_gen2.sv
// 68000-bus DRAM controller: RAS/CAS access sequencing with CAS-before-RAS refresh.
module dram_ctl_gen2
    import dram_gen2_pkg::*;
#(
    parameter int unsigned ROW_W      = 11,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned BANKS      = 2,
    parameter int unsigned T_RCD      = DefTRcd,
    parameter int unsigned T_RP       = DefTRp,
    parameter int unsigned T_RFC      = DefTRfc,
    parameter int unsigned REF_PERIOD = DefRefPeriod,
    parameter int unsigned REF_MAX    = DefRefMax,
    localparam int unsigned BSEL_W    = width_of(BANKS)
) (
    input  logic                          CLK,
    input  logic                          nRESET,
    input  logic [ROW_W+COL_W+BSEL_W-1:0] A,
    input  logic                          nAS,
    input  logic                          nUDS,
    input  logic                          nLDS,
    input  logic                          nWE,
    input  logic                          nDTACK,
    input  logic                          RAMCS,
    output logic                          RAMReady,
    output logic [ROW_W-1:0]              RA,
    output logic [BANKS-1:0]              nRAS,
    output logic                          nCAS,
    output logic                          nLWE,
    output logic                          nUWE,
    output logic                          nOE,
    output logic [1:0]                    RefPend
);

    localparam int unsigned   CntW  = width_of(max3(T_RCD, T_RP, T_RFC));
    localparam logic [CntW-1:0] LdRcd = CntW'(T_RCD - 1);
    localparam logic [CntW-1:0] LdRp  = CntW'(T_RP - 1);
    localparam logic [CntW-1:0] LdRfc = CntW'(T_RFC - 1);

    dram_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BSEL_W-1:0] bank_q, bank_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  ra_d;
    logic [BANKS-1:0]  ras_d;
    logic              cas_d, oe_d, lwe_d, uwe_d, ready_d;
    logic              pending, urgent, urgent_next, hold_done, ref_done;

    assign hold_done = (cnt_q == '0);
    assign ref_done  = (state_q == StRpre) && hold_done;

    dram_refresh_timer #(
        .REF_PERIOD (REF_PERIOD),
        .REF_MAX    (REF_MAX)
    ) u_refresh_timer (
        .clk_i         (CLK),
        .rst_ni        (nRESET),
        .dec_i         (ref_done),
        .pending_o     (pending),
        .urgent_o      (urgent),
        .urgent_next_o (urgent_next),
        .ref_pend_o    (RefPend)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = hold_done ? cnt_q : cnt_q - 1'b1;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            StIdle: begin
                if (urgent) begin
                    state_d = StRcas;
                    cnt_d   = '0;
                end else if (!nAS && RAMCS) begin
                    state_d = StRow;
                    cnt_d   = LdRcd;
                    bank_d  = (BANKS > 1) ? A[ROW_W+COL_W +: BSEL_W] : '0;
                    row_d   = A[COL_W +: ROW_W];
                    col_d   = A[COL_W-1:0];
                end else if (pending && (nAS || !RAMCS)) begin
                    state_d = StRcas;
                    cnt_d   = '0;
                end
            end
            StRow: begin
                if (nAS) begin
                    state_d = StPre;
                    cnt_d   = LdRp;
                end else if (hold_done) begin
                    state_d = StCol;
                    cnt_d   = '0;
                end
            end
            StCol: begin
                if (!nDTACK || nAS) begin
                    state_d = StPre;
                    cnt_d   = LdRp;
                end
            end
            StPre:  if (hold_done) state_d = StIdle;
            StRcas: begin
                state_d = StRras;
                cnt_d   = LdRfc;
            end
            StRras: begin
                if (hold_done) begin
                    state_d = StRpre;
                    cnt_d   = LdRp;
                end
            end
            StRpre: if (hold_done) state_d = StIdle;
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        ra_d  = '0;
        ras_d = '1;
        cas_d = 1'b1;
        oe_d  = 1'b1;
        lwe_d = 1'b1;
        uwe_d = 1'b1;
        case (state_d)
            StRow: begin
                ras_d = ~(BANKS'(1) << bank_d);
                ra_d  = row_d;
            end
            StCol: begin
                ras_d = ~(BANKS'(1) << bank_d);
                ra_d  = ROW_W'(col_d);
                cas_d = 1'b0;
                if (nWE) begin
                    oe_d = 1'b0;
                end else begin
                    lwe_d = nLDS;
                    uwe_d = nUDS;
                end
            end
            StRcas: cas_d = 1'b0;
            StRras: begin
                ras_d = '0;
                cas_d = 1'b0;
            end
            default: ;
        endcase
        ready_d = !((state_d == StRcas) || (state_d == StRras) || (state_d == StRpre) ||
                    ((state_d == StIdle) && urgent_next));
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bank_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            RA       <= '0;
            nRAS     <= '1;
            nCAS     <= 1'b1;
            nOE      <= 1'b1;
            nLWE     <= 1'b1;
            nUWE     <= 1'b1;
            RAMReady <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            row_q    <= row_d;
            col_q    <= col_d;
            RA       <= ra_d;
            nRAS     <= ras_d;
            nCAS     <= cas_d;
            nOE      <= oe_d;
            nLWE     <= lwe_d;
            nUWE     <= uwe_d;
            RAMReady <= ready_d;
        end
    end

endmodule

// File: tb/tb_dram_ctl_gen2.sv
// Directed bench for dram_ctl_gen2: CAS-cycle scoreboard plus cycle-exact refresh checks.
module tb_dram_ctl_gen2;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic [21:0] A = '0;
    logic        nAS = 1'b1, nUDS = 1'b1, nLDS = 1'b1, nWE = 1'b1, nDTACK = 1'b1, RAMCS = 1'b0;
    logic        RAMReady, nCAS, nLWE, nUWE, nOE;
    logic [10:0] RA;
    logic [1:0]  nRAS, RefPend;

    typedef struct packed {
        logic [1:0] nras;
        logic [9:0] col;
        logic       oe;
        logic       lwe;
        logic       uwe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   e = 0;
    int   low_cnt;
    logic prev_cas = 1'b1;

    always #5 CLK = ~CLK;

    dram_ctl_gen2 dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .A        (A),
        .nAS      (nAS),
        .nUDS     (nUDS),
        .nLDS     (nLDS),
        .nWE      (nWE),
        .nDTACK   (nDTACK),
        .RAMCS    (RAMCS),
        .RAMReady (RAMReady),
        .RA       (RA),
        .nRAS     (nRAS),
        .nCAS     (nCAS),
        .nLWE     (nLWE),
        .nUWE     (nUWE),
        .nOE      (nOE),
        .RefPend  (RefPend)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        e++;
    endtask

    task automatic step_to(input int n);
        while (e < n) step();
    endtask

    task automatic bus_idle();
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; nWE = 1'b1; nDTACK = 1'b1; RAMCS = 1'b0;
        A = '0;
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        bus_idle();
        sb.delete();
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        e = 0;
    endtask

    task automatic push_exp(input logic [21:0] addr, input logic wr, input logic lds,
                            input logic uds);
        exp_t x;
        x.nras = addr[21] ? 2'b01 : 2'b10;
        x.col  = addr[9:0];
        x.oe   = wr;
        x.lwe  = wr ? lds : 1'b1;
        x.uwe  = wr ? uds : 1'b1;
        sb.push_back(x);
    endtask

    // Full read cycle; returns on the edge that enters precharge, with nAS released.
    task automatic access(input logic [21:0] addr);
        A = addr; RAMCS = 1'b1; nWE = 1'b1; nLDS = 1'b0; nUDS = 1'b0; nAS = 1'b0;
        push_exp(addr, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && nCAS !== 1'b0; i++) step();
        check("access_cas_timeout", nCAS, 0);
        nDTACK = 1'b0;
        step();
        nDTACK = 1'b1;
        nAS = 1'b1;
    endtask

    // Every access CAS edge must match the oldest outstanding access.
    always @(negedge CLK) begin
        if (nRESET === 1'b1 && prev_cas === 1'b1 && nCAS === 1'b0 && nRAS !== 2'b11) begin
            if (sb.size() == 0) begin
                check("cas_without_access", sb.size(), 1);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("cas_bank", nRAS, x.nras);
                check("cas_col", RA, 32'(x.col));
                check("cas_oe", nOE, x.oe);
                check("cas_lwe", nLWE, x.lwe);
                check("cas_uwe", nUWE, x.uwe);
            end
        end
        prev_cas <= nCAS;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        bus_idle();
        #12;
        check("rst_ra", RA, 0);
        check("rst_nras", nRAS, 2'b11);
        check("rst_strobes", {nCAS, nOE, nLWE, nUWE}, 4'hF);
        check("rst_ready", RAMReady, 1);
        check("rst_refpend", RefPend, 0);

        // Read, bank 1, row 0x155, col 0x0AA
        do_reset();
        A = {1'b1, 11'h155, 10'h0AA}; RAMCS = 1'b1; nWE = 1'b1; nLDS = 1'b0; nUDS = 1'b0;
        nAS = 1'b0;
        push_exp(A, 1'b0, 1'b0, 1'b0);
        step();
        check("rd_row_nras", nRAS, 2'b01);
        check("rd_row_ra", RA, 11'h155);
        check("rd_row_cas", nCAS, 1);
        step();
        check("rd_col_ra", RA, 11'h0AA);
        check("rd_col_cas_oe", {nCAS, nOE}, 2'b00);
        step();
        check("rd_col_hold", {nCAS, nOE}, 2'b00);
        nDTACK = 1'b0;
        step();
        check("rd_pre", {nRAS, nCAS, nOE}, 4'hF);
        // Byte write queued while precharging
        nDTACK = 1'b1;
        A = {1'b0, 11'h2AB, 10'h3C5}; nWE = 1'b0; nLDS = 1'b0; nUDS = 1'b1;
        push_exp(A, 1'b1, 1'b0, 1'b1);
        step();
        check("pre_cycle2_nras", nRAS, 2'b11);
        step();
        check("idle_wait_nras", nRAS, 2'b11);
        step();
        check("wr_row_nras", nRAS, 2'b10);
        check("wr_row_ra", RA, 11'h2AB);
        step();
        check("wr_col", {nCAS, nOE, nLWE, nUWE}, 4'b0101);
        check("wr_col_ra", RA, 11'h3C5);
        nDTACK = 1'b0;
        step();
        check("wr_pre", {nCAS, nLWE, nUWE}, 3'b111);
        bus_idle();

        // Abort during ROW
        step_to(11);
        A = {1'b1, 11'h001, 10'h002}; RAMCS = 1'b1; nAS = 1'b0;
        step();
        check("abort_row_nras", nRAS, 2'b01);
        nAS = 1'b1;
        step();
        check("abort_pre", {nRAS, nCAS}, 3'b111);
        step();
        step();
        check("abort_no_cas", {nRAS, nCAS}, 3'b111);
        check("sb_drained_1", sb.size(), 0);
        bus_idle();

        // Idle refresh
        do_reset();
        step_to(119);
        check("ref_pend_119", RefPend, 0);
        step();
        check("ref_pend_120", RefPend, 1);
        low_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] exp_t6 [6];
            exp_t6 = '{4'b1100, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 4'b1111};
            step();
            check($sformatf("cbr_seq_%0d", 121 + i), {nRAS, nCAS, RAMReady}, exp_t6[i]);
            if (RAMReady === 1'b0) low_cnt++;
        end
        check("cbr_ready_low_cycles", low_cnt, 5);
        check("cbr_refpend_after", RefPend, 0);

        // Timer wrap on the RPRE exit edge
        do_reset();
        A = {1'b0, 11'h100, 10'h010}; RAMCS = 1'b1; nWE = 1'b1; nLDS = 1'b0; nUDS = 1'b0;
        nAS = 1'b0;
        push_exp(A, 1'b0, 1'b0, 1'b0);
        step_to(120);
        check("long_col_refpend", RefPend, 1);
        check("long_col_cas", nCAS, 0);
        step_to(231);
        nDTACK = 1'b0;
        step_to(232);
        check("long_pre", nRAS, 2'b11);
        bus_idle();
        step_to(235);
        check("wrap_rcas", {nRAS, nCAS, RAMReady}, 4'b1100);
        step_to(239);
        check("wrap_refpend_239", RefPend, 1);
        step_to(240);
        check("wrap_refpend_240", RefPend, 1);
        check("wrap_ready_240", RAMReady, 1);
        step_to(241);
        check("wrap_second_rcas", nCAS, 0);

        // Back-to-back accesses until refresh becomes urgent
        do_reset();
        for (int i = 0; e < 355; i++) access({1'(i % 2), 11'(i * 37), 10'(i * 13)});
        check("b2b_end_edge", e, 358);
        A = {1'b0, 11'h7FF, 10'h3FF}; RAMCS = 1'b1; nWE = 1'b1; nAS = 1'b0;
        step();
        check("b2b_refpend_359", RefPend, 2);
        step();
        check("urgent_refpend", RefPend, 3);
        check("urgent_idle", {nRAS, nCAS, RAMReady}, 4'b1110);
        step();
        check("urgent_rcas", {nRAS, nCAS, RAMReady}, 4'b1100);
        step();
        check("urgent_rras", {nRAS, nCAS}, 3'b000);
        // Reset in the middle of RRAS
        nRESET = 1'b0;
        #1;
        check("rst_rras_strobes", {nRAS, nCAS, nOE, nLWE, nUWE}, 6'h3F);
        check("rst_rras_refpend", RefPend, 0);
        check("rst_rras_ready", RAMReady, 1);
        sb.delete();
        bus_idle();
        @(negedge CLK);
        nRESET = 1'b1;
        e = 0;
        step_to(3);
        check("post_rst_quiet", {nRAS, nCAS}, 3'b111);
        check("sb_drained_2", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_ctl_gen2.md
DRAM_CTL_GEN2 -- requirements
Module: dram_ctl_gen2

Interface
REQ-001 SHALL have parameter ROW_W, default 11, row/RA bus width, with ROW_W >= COL_W.
REQ-002 SHALL have parameter COL_W, default 10, column address width.
REQ-003 SHALL have parameter BANKS, default 2, count of /RAS banks (power of 2, >=1); BSEL_W = clog2(BANKS), min 1.
REQ-004 SHALL have parameters T_RCD=1, T_RP=2, T_RFC=2, REF_PERIOD=120, REF_MAX=3, all in CLK cycles.
REQ-005 SHALL have port CLK  in  1  system clock; all logic on rising edge only.
REQ-006 SHALL have port nRESET  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port A  in  ROW_W+COL_W+BSEL_W  word address: bank=MSBs, row=middle, column=LSBs.
REQ-008 SHALL have ports nAS, nUDS, nLDS, nWE, nDTACK  in  1 each  68000 bus strobes.
REQ-009 SHALL have port RAMCS  in  1  decoded RAM select.
REQ-010 SHALL have port RAMReady  out  1  registered; high means a RAM access may be terminated.
REQ-011 SHALL have ports RA out ROW_W, nRAS out BANKS, nCAS out 1, nLWE, nUWE, nOE out 1 each; all registered.
REQ-012 SHALL have port RefPend  out  2  pending-refresh count, debug only.

Function
REQ-013 Refresh timer SHALL count 0..REF_PERIOD-1 and wrap; each wrap increments RefPend, saturating at REF_MAX.
REQ-014 RefPend decrements by 1 on leaving RPRE; wrap and decrement in the same cycle SHALL leave RefPend unchanged.
REQ-015 Urgent = (RefPend == REF_MAX); Pending = (RefPend != 0).
REQ-016 States SHALL be IDLE, ROW, COL, PRE, RCAS, RRAS, RPRE.
REQ-017 IDLE priority: Urgent -> RCAS; else (!nAS && RAMCS) -> ROW; else Pending && (nAS || !RAMCS) -> RCAS; else stay.
REQ-018 ROW: nRAS[bank] low, RA=row; held T_RCD cycles, then COL; nAS high in ROW -> PRE (abort).
REQ-019 COL: RA=column (zero-extended), nCAS low; read: nOE low; write: nLWE=nLDS, nUWE=nUDS; stay until nDTACK low or nAS high, then PRE.
REQ-020 PRE: all nRAS, nCAS, nOE, nLWE, nUWE high; held T_RP cycles, then IDLE.
REQ-021 RCAS (CAS-before-RAS): nCAS low, all nRAS high, 1 cycle -> RRAS.
REQ-022 RRAS: all nRAS low, nCAS low; held T_RFC cycles -> RPRE.
REQ-023 RPRE: all strobes high; held T_RP cycles -> IDLE.
REQ-024 RAMReady SHALL be low in RCAS/RRAS/RPRE and in IDLE while Urgent; high otherwise.
REQ-025 RA access arriving while not IDLE SHALL wait in IDLE next; latency nAS-sampled-low to nCAS low = 1+T_RCD cycles from IDLE.
REQ-026 Only one nRAS bit SHALL be low during ROW/COL; nRAS and nCAS SHALL never both be low outside COL, RCAS, RRAS.
REQ-027 State hold counters SHALL be sized for max(T_RCD,T_RP,T_RFC) and reload on every state entry.

Reset
REQ-028 nRESET low SHALL immediately force state IDLE, timer 0, RefPend 0, all nRAS/nCAS/nOE/nLWE/nUWE high, RA 0, RAMReady high.
REQ-029 Reset asserted mid-access or mid-refresh SHALL abandon the operation with no further strobe pulses; release is synchronous to CLK.

Structure
REQ-030 Package dram_gen2_pkg SHALL hold the state enumeration and default timing constants.
REQ-031 Sub-module dram_refresh_timer SHALL contain the timer and RefPend counter, outputs Pending and Urgent.

Verification
REQ-032 Read: RAMCS=1, nAS low, bank 1, row 0x155, col 0x0AA -> nRAS[1] low 1 cycle, RA=0x155 then 0x0AA, nCAS/nOE low until nDTACK low, then 2 cycles precharge.
REQ-033 Byte write: nWE low, nLDS low, nUDS high -> nLWE low during COL, nUWE stays high.
REQ-034 Idle bus 120 cycles -> RefPend 1, CBR sequence RCAS(1)/RRAS(2)/RPRE(2), RefPend back to 0, RAMReady low 5 cycles.
REQ-035 Back-to-back RAM accesses for 360 cycles -> RefPend reaches 3, next IDLE enters RCAS ahead of a pending RAM access, RAMReady low.
REQ-036 nAS rises during ROW -> PRE, no nCAS pulse; nRESET low during RRAS -> all strobes high at once, RefPend 0.
REQ-037 Timer wrap in the exit cycle of RPRE -> RefPend unchanged.
